// File: rtl/jt6295_romarb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jt6295_romarb : shares the jt6295 ADPCM ROM port between control and voices
// Revision 1.0
// ---------------------------------------------------------------------------
module jt6295_romarb #(
    parameter int AW   = 18,
    parameter int DW   = 8,
    parameter int TOUT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      req,
    input  logic [5*AW-1:0] addr,
    output logic [4:0]      ack,
    output logic [DW-1:0]   data,
    output logic            err,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic [DW-1:0]   rom_data,
    input  logic            rom_ok
);

    localparam logic [15:0] C_TOUT_LAST = 16'(TOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_grant;
    logic [1:0]      r_last;
    logic [15:0]     r_cnt;
    logic [2:0]      w_win;
    logic [AW-1:0]   w_sel_addr;

    // Control always wins; channels rotate starting after the last one served.
    always_comb begin
        w_win = 3'd4;
        if (!req[4]) begin
            w_win = 3'd0;
            for (int k = 4; k >= 1; k--) begin
                if (req[r_last + 2'(k)]) w_win = {1'b0, r_last + 2'(k)};
            end
        end
    end

    always_comb begin
        case (w_win)
            3'd0:    w_sel_addr = addr[0*AW +: AW];
            3'd1:    w_sel_addr = addr[1*AW +: AW];
            3'd2:    w_sel_addr = addr[2*AW +: AW];
            3'd3:    w_sel_addr = addr[3*AW +: AW];
            default: w_sel_addr = addr[4*AW +: AW];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_grant  <= 3'd0;
            r_last   <= 2'd3;
            r_cnt    <= 16'd0;
            ack      <= 5'd0;
            err      <= 1'b0;
            data     <= '0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ack    <= 5'd0;
                    err    <= 1'b0;
                    rom_cs <= 1'b0;
                    if (|req) begin
                        rom_addr <= w_sel_addr;
                        r_grant  <= w_win;
                        if (!w_win[2]) r_last <= w_win[1:0];
                        rom_cs   <= 1'b1;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    // rom_ok may still refer to the previous address here
                    r_cnt   <= 16'd0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (rom_ok) begin
                        data    <= rom_data;
                        ack     <= 5'b00001 << r_grant;
                        r_state <= DONE;
                    end else if (r_cnt == C_TOUT_LAST) begin
                        data    <= '0;
                        ack     <= 5'b00001 << r_grant;
                        err     <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DONE: begin
                    ack     <= 5'd0;
                    err     <= 1'b0;
                    rom_cs  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt6295_romarb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jt6295_romarb : directed and randomized checks of the ROM arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_jt6295_romarb;
    localparam int AW = 18;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [4:0]      req, req_b;
    logic [5*AW-1:0] addr, addr_b;
    logic [4:0]      ack, ack_b;
    logic [DW-1:0]   data, data_b;
    logic            err, err_b;
    logic [AW-1:0]   rom_addr, rom_addr_b;
    logic            rom_cs, rom_cs_b;
    logic [DW-1:0]   rom_data, rom_data_b;
    logic            rom_ok, rom_ok_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt6295_romarb #(.AW(AW), .DW(DW), .TOUT(255)) dut (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr), .ack(ack), .data(data),
        .err(err), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    jt6295_romarb #(.AW(AW), .DW(DW), .TOUT(4)) dut_b (
        .clk(clk), .rstn(rstn), .req(req_b), .addr(addr_b), .ack(ack_b), .data(data_b),
        .err(err_b), .rom_addr(rom_addr_b), .rom_cs(rom_cs_b), .rom_data(rom_data_b), .rom_ok(rom_ok_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0; req = '0; req_b = '0; addr = '0; addr_b = '0;
        rom_ok = 1'b0; rom_ok_b = 1'b0; rom_data = '0; rom_data_b = '0;
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Reference arbitration rule: control first, then channels after the last served
    function automatic int pick(input logic [4:0] r, input int last);
        if (r[4]) return 4;
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] romf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h3C;
    endfunction

    task automatic test_reset;
        rstn = 1'b0; req = '0; req_b = '0; addr = '0; addr_b = '0;
        rom_ok = 1'b0; rom_ok_b = 1'b0; rom_data = '0; rom_data_b = '0;
        tick;
        checks++; if (ack !== 5'd0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (rom_addr !== 18'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
        checks++; if (rom_cs_b !== 1'b0 || ack_b !== 5'd0) begin errors++; $display("FAIL reset_b: got cs=%b ack=%b expected 0", rom_cs_b, ack_b); end
    endtask

    task automatic test_single;
        do_reset;
        rom_ok = 1'b1; rom_data = 8'h5A; addr[0 +: AW] = 18'h00400; req = 5'b00001;
        tick; // edge 0
        checks++; if (rom_addr !== 18'h00400) begin errors++; $display("FAIL single_rom_addr: got %h expected 00400", rom_addr); end
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL single_rom_cs: got %b expected 1", rom_cs); end
        checks++; if (ack !== 5'd0) begin errors++; $display("FAIL single_ack_e0: got %b expected 0", ack); end
        tick; // edge 1
        checks++; if (ack !== 5'd0) begin errors++; $display("FAIL single_ack_e1: got %b expected 0", ack); end
        tick; // edge 2
        checks++; if (ack !== 5'b00001) begin errors++; $display("FAIL single_ack_e2: got %b expected 00001", ack); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL single_data: got %h expected 5a", data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
        req = 5'b00000;
        tick; // edge 3
        checks++; if (ack !== 5'd0) begin errors++; $display("FAIL single_ack_e3: got %b expected 0", ack); end
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL single_cs_e3: got %b expected 0", rom_cs); end
        checks++; if (data !== 8'h5A) begin errors++; $display("FAIL single_data_hold: got %h expected 5a", data); end
    endtask

    task automatic run_sequence(input string name, input logic [4:0] start_req,
                                input logic [4:0] exp_a0, input logic [4:0] exp_a1,
                                input logic [4:0] exp_a2, input logic [4:0] exp_a3,
                                input logic [4:0] exp_a4);
        logic [4:0] exp_a [5];
        int n = 0;
        exp_a[0] = exp_a0; exp_a[1] = exp_a1; exp_a[2] = exp_a2; exp_a[3] = exp_a3; exp_a[4] = exp_a4;
        do_reset;
        rom_ok = 1'b1; rom_data = 8'h11; req = start_req;
        for (int i = 0; i < 5; i++) addr[i*AW +: AW] = 18'(i * 18'h100 + 18'h20);
        for (int e = 0; e < 20; e++) begin
            tick;
            if (ack !== 5'd0) begin
                checks++;
                if (n >= 5) begin
                    errors++; $display("FAIL %s_extra_ack: got %b at edge %0d expected none", name, ack, e);
                end else begin
                    if (e !== 4 * n + 2) begin errors++; $display("FAIL %s_ack_edge%0d: got edge %0d expected %0d", name, n, e, 4 * n + 2); end
                    checks++;
                    if (ack !== exp_a[n]) begin errors++; $display("FAIL %s_grant%0d: got %b expected %b", name, n, ack, exp_a[n]); end
                end
                if (ack[4]) req[4] = 1'b0;
                n++;
                if (n == 5) req = 5'b00000;
            end
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL %s_count: got %0d acks expected 5", name, n); end
    endtask

    task automatic test_round_robin;
        run_sequence("rr", 5'b01111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00001);
    endtask

    task automatic test_control_priority;
        run_sequence("ctl", 5'b10110, 5'b10000, 5'b00010, 5'b00100, 5'b00010, 5'b00100);
    endtask

    task automatic test_stall;
        int first = -1;
        logic [4:0] got_a = '0;
        logic [7:0] got_d = '0;
        logic got_e = 1'b0;
        do_reset;
        addr[2*AW +: AW] = 18'h1ABCD; req = 5'b00100;
        for (int e = 0; e < 16; e++) begin
            if (e == 1) begin rom_ok = 1'b1; rom_data = 8'hFF; end
            else if (e < 12) begin rom_ok = 1'b0; rom_data = 8'hEE; end
            else begin rom_ok = 1'b1; rom_data = 8'hC3; end
            tick;
            if (ack !== 5'd0 && first < 0) begin
                first = e; got_a = ack; got_d = data; got_e = err; req = 5'b00000;
            end
        end
        checks++; if (first !== 12) begin errors++; $display("FAIL stall_ack_edge: got %0d expected 12", first); end
        checks++; if (got_a !== 5'b00100) begin errors++; $display("FAIL stall_ack: got %b expected 00100", got_a); end
        checks++; if (got_d !== 8'hC3) begin errors++; $display("FAIL stall_data: got %h expected c3", got_d); end
        checks++; if (got_e !== 1'b0) begin errors++; $display("FAIL stall_err: got %b expected 0", got_e); end
        checks++; if (rom_addr !== 18'h1ABCD) begin errors++; $display("FAIL stall_rom_addr: got %h expected 1abcd", rom_addr); end
    endtask

    task automatic test_timeout;
        do_reset;
        req_b = 5'b00001; rom_ok_b = 1'b1; rom_data_b = 8'hA5;
        tick; tick; tick;
        checks++; if (ack_b !== 5'b00001 || data_b !== 8'hA5) begin errors++; $display("FAIL tout_pre: got ack=%b data=%h expected 00001/a5", ack_b, data_b); end
        req_b = 5'b00000;
        tick;
        for (int k = 0; k < 2; k++) begin
            int first = -1;
            logic [4:0] got_a = '0;
            logic [7:0] got_d = 8'hFF;
            logic got_e = 1'b0;
            req_b = 5'b01000; addr_b[3*AW +: AW] = 18'(18'h2F000 + k); rom_ok_b = 1'b0; rom_data_b = 8'h77;
            for (int e = 0; e < 7; e++) begin
                tick;
                checks++; if (err_b === 1'b1 && ack_b === 5'd0) begin errors++; $display("FAIL tout_err_alone: got err=1 ack=0 expected err only with ack"); end
                if (ack_b !== 5'd0 && first < 0) begin
                    first = e; got_a = ack_b; got_d = data_b; got_e = err_b; req_b = 5'b00000;
                end
                if (e == 6) begin
                    checks++; if (ack_b !== 5'd0 || err_b !== 1'b0 || rom_cs_b !== 1'b0) begin errors++; $display("FAIL tout_after%0d: got ack=%b err=%b cs=%b expected 0/0/0", k, ack_b, err_b, rom_cs_b); end
                end
            end
            checks++; if (first !== 5) begin errors++; $display("FAIL tout_edge%0d: got %0d expected 5", k, first); end
            checks++; if (got_a !== 5'b01000) begin errors++; $display("FAIL tout_ack%0d: got %b expected 01000", k, got_a); end
            checks++; if (got_e !== 1'b1) begin errors++; $display("FAIL tout_err%0d: got %b expected 1", k, got_e); end
            checks++; if (got_d !== 8'h00) begin errors++; $display("FAIL tout_data%0d: got %h expected 00", k, got_d); end
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset;
        rom_ok = 1'b1; rom_data = 8'h77; req = 5'b00010;
        tick; tick; tick;
        req = 5'b00000;
        tick;
        req = 5'b00100; rom_ok = 1'b0;
        tick; tick; tick; tick;
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL rmw_cs_before: got %b expected 1", rom_cs); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rmw_cs: got %b expected 0", rom_cs); end
        checks++; if (ack !== 5'd0) begin errors++; $display("FAIL rmw_ack: got %b expected 0", ack); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmw_data: got %h expected 00", data); end
        checks++; if (rom_addr !== 18'h0) begin errors++; $display("FAIL rmw_rom_addr: got %h expected 0", rom_addr); end
        @(posedge clk);
        #1;
        rstn = 1'b1; req = 5'b00101; rom_ok = 1'b1; rom_data = 8'h42;
        tick; tick; tick;
        checks++; if (ack !== 5'b00001) begin errors++; $display("FAIL rmw_first_prio: got %b expected 00001", ack); end
        req = 5'b00000;
        tick;
    endtask

    task automatic test_random(input int ncyc);
        int busy = 0, t0 = 0, ack_e = 0, w = 0, ptr = 3, next_arb = 0, s;
        logic [AW-1:0] caddr = '0, exp_raddr = '0;
        logic [7:0] exp_data = 8'h00;
        logic [4:0] exp_ack;
        logic exp_cs;
        do_reset;
        for (int e = 0; e < ncyc; e++) begin
            for (int i = 0; i < 5; i++)
                if (!req[i] && $urandom_range((i == 4) ? 7 : 3) == 0) begin
                    req[i] = 1'b1; addr[i*AW +: AW] = 18'($urandom);
                end
            if (busy == 0 && e >= next_arb && req != 5'd0) begin
                w = pick(req, ptr);
                if (w < 4) ptr = w;
                busy = 1; t0 = e; caddr = addr[w*AW +: AW];
                s = ($urandom_range(7) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 2));
                ack_e = e + 2 + s;
            end
            if (busy != 0 && e >= t0 + 2 && e < ack_e) begin rom_ok = 1'b0; rom_data = 8'($urandom); end
            else if (busy != 0 && e == ack_e) begin rom_ok = 1'b1; rom_data = romf(caddr); end
            else begin rom_ok = 1'($urandom_range(1)); rom_data = 8'($urandom); end
            tick;
            if (busy != 0 && e == t0) exp_raddr = caddr;
            exp_ack = (busy != 0 && e == ack_e) ? 5'(5'b00001 << w) : 5'd0;
            if (busy != 0 && e == ack_e) exp_data = romf(caddr);
            exp_cs = (busy != 0 && e >= t0 && e <= ack_e);
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_ack@%0d: got %b expected %b", e, ack, exp_ack); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err@%0d: got %b expected 0", e, err); end
            checks++; if (data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", e, data, exp_data); end
            checks++; if (rom_addr !== exp_raddr) begin errors++; $display("FAIL rnd_rom_addr@%0d: got %h expected %h", e, rom_addr, exp_raddr); end
            checks++; if (rom_cs !== exp_cs) begin errors++; $display("FAIL rnd_cs@%0d: got %b expected %b", e, rom_cs, exp_cs); end
            if (busy != 0 && e == ack_e) req[w] = 1'b0;
            if (busy != 0 && e == ack_e + 1) begin busy = 0; next_arb = e + 1; end
        end
        req = 5'd0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_control_priority;
        test_stall;
        test_timeout;
        test_reset_mid_wait;
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
